// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_unit
//  Purpose  : Load-use stall, taken-branch flush and dmem-wait freeze control
//             for the ID-stage control mux. Optional perf counters are built
//             when HAZARD_PERF_CNT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl_unit #(
    parameter int FLUSH_CYCLES   = 2,
    parameter int FREEZE_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs2,
    input  logic [4:0]  id_ex_rd,
    input  logic        id_ex_MemRead,
    input  logic        ex_branch_taken,
    input  logic        dmem_busy,
    output logic        ctrl_sgnl_sel,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        pipe_freeze,
    output logic        freeze_timeout,
    output logic [1:0]  hz_state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_FLUSH = 2'b01;

    localparam logic [2:0] C_FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] C_BUSY_LIMIT   = 8'(FREEZE_TIMEOUT - 1);

    logic [1:0] r_st;
    logic [2:0] r_fcnt;
    logic [7:0] r_bcnt;
    logic       r_timeout;

    logic       w_load_use;
    logic       w_flush_case;

    // x0 is hard-wired zero, so a load targeting it can never create a hazard.
    assign w_load_use = id_ex_MemRead && (id_ex_rd != 5'd0) &&
                        ((id_ex_rd == id_rs1) || (id_uses_rs2 && (id_ex_rd == id_rs2)));

    assign w_flush_case = !dmem_busy && (ex_branch_taken || (r_st == ST_FLUSH));

    assign hz_state       = r_st;
    assign freeze_timeout = r_timeout;

    always_comb begin
        ctrl_sgnl_sel = 1'b1;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        pipe_freeze   = 1'b0;
        if (rst) begin
            ctrl_sgnl_sel = 1'b0;
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            if_id_flush   = 1'b1;
        end else if (dmem_busy) begin
            pipe_freeze   = 1'b1;
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
        end else if (w_flush_case) begin
            ctrl_sgnl_sel = 1'b0;
            if_id_flush   = 1'b1;
        end else if (w_load_use) begin
            ctrl_sgnl_sel = 1'b0;
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st      <= ST_RUN;
            r_fcnt    <= 3'd0;
            r_bcnt    <= 8'd0;
            r_timeout <= 1'b0;
        end else if (dmem_busy) begin
            // Freeze: flush window is held; only the watchdog advances.
            if (r_bcnt != 8'hFF) begin
                r_bcnt <= r_bcnt + 8'd1;
            end
            if (r_bcnt == C_BUSY_LIMIT) begin
                r_timeout <= 1'b1;
            end
        end else begin
            r_bcnt <= 8'd0;
            if (ex_branch_taken) begin
                if (FLUSH_CYCLES > 1) begin
                    r_st   <= ST_FLUSH;
                    r_fcnt <= C_FLUSH_RELOAD;
                end
            end else if (r_st == ST_FLUSH) begin
                r_fcnt <= r_fcnt - 3'd1;
                if (r_fcnt == 3'd1) begin
                    r_st <= ST_RUN;
                end
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic        w_stall_case;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    assign w_stall_case = !dmem_busy && !w_flush_case && w_load_use;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 16'h0000;
            r_flush_cnt <= 16'h0000;
        end else begin
            if (w_stall_case) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_flush_case) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = 16'h0000;
    assign flush_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl_unit
//  Purpose  : Directed self-checking bench for hazard_ctrl_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs2;
    logic [4:0]  id_ex_rd;
    logic        id_ex_MemRead;
    logic        ex_branch_taken;
    logic        dmem_busy;
    logic        ctrl_sgnl_sel;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        pipe_freeze;
    logic        freeze_timeout;
    logic [1:0]  hz_state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic [4:0]  outs;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Output vector order: {ctrl_sgnl_sel, pc_write, if_id_write, if_id_flush, pipe_freeze}
    localparam logic [4:0] O_RUN    = 5'b11100;
    localparam logic [4:0] O_STALL  = 5'b00000;
    localparam logic [4:0] O_FLUSH  = 5'b01110;
    localparam logic [4:0] O_FREEZE = 5'b10001;
    localparam logic [4:0] O_RESET  = 5'b00010;

    assign outs = {ctrl_sgnl_sel, pc_write, if_id_write, if_id_flush, pipe_freeze};

    always #5 clk = ~clk;

    hazard_ctrl_unit #(
        .FLUSH_CYCLES   (2),
        .FREEZE_TIMEOUT (64)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs2     (id_uses_rs2),
        .id_ex_rd        (id_ex_rd),
        .id_ex_MemRead   (id_ex_MemRead),
        .ex_branch_taken (ex_branch_taken),
        .dmem_busy       (dmem_busy),
        .ctrl_sgnl_sel   (ctrl_sgnl_sel),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .pipe_freeze     (pipe_freeze),
        .freeze_timeout  (freeze_timeout),
        .hz_state        (hz_state),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1          = 5'd0;
        id_rs2          = 5'd0;
        id_uses_rs2     = 1'b0;
        id_ex_rd        = 5'd0;
        id_ex_MemRead   = 1'b0;
        ex_branch_taken = 1'b0;
        dmem_busy       = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic uses2);
        id_ex_MemRead = 1'b1;
        id_ex_rd      = rd;
        id_rs1        = rs1;
        id_rs2        = rs2;
        id_uses_rs2   = uses2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        #2;
        n_checks++;
        if (outs !== O_RESET) begin
            n_fail++; $display("FAIL reset_outs: got %b expected %b", outs, O_RESET);
        end
        n_checks++;
        if (hz_state !== 2'b00 || freeze_timeout !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: hz=%b tmo=%b expected 00/0", hz_state, freeze_timeout);
        end
        n_checks++;
        if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin
            n_fail++; $display("FAIL reset_cnt: stall=%0d flush=%0d expected 0/0", stall_cnt, flush_cnt);
        end
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (outs !== O_RUN) begin
            n_fail++; $display("FAIL reset_release: got %b expected %b", outs, O_RUN);
        end
        tick();
    endtask

    task automatic test_load_use();
        load_use(5'd5, 5'd5, 5'd0, 1'b0);
        #1;
        n_checks++;
        if (outs !== O_STALL || hz_state !== 2'b00) begin
            n_fail++; $display("FAIL lu_rs1: got %b hz=%b expected %b hz=00", outs, hz_state, O_STALL);
        end
        tick();
        id_ex_MemRead = 1'b0;
        #1;
        n_checks++;
        if (outs !== O_RUN) begin
            n_fail++; $display("FAIL lu_release: got %b expected %b", outs, O_RUN);
        end
        tick();
        load_use(5'd7, 5'd3, 5'd7, 1'b1);
        #1;
        n_checks++;
        if (outs !== O_STALL) begin
            n_fail++; $display("FAIL lu_rs2: got %b expected %b", outs, O_STALL);
        end
        id_uses_rs2 = 1'b0;
        #1;
        n_checks++;
        if (outs !== O_RUN) begin
            n_fail++; $display("FAIL lu_rs2_unused: got %b expected %b", outs, O_RUN);
        end
        tick();
        idle();
    endtask

    task automatic test_x0();
        load_use(5'd0, 5'd0, 5'd0, 1'b1);
        #1;
        n_checks++;
        if (outs !== O_RUN) begin
            n_fail++; $display("FAIL x0_no_stall: got %b expected %b", outs, O_RUN);
        end
        id_ex_MemRead = 1'b0;
        id_ex_rd      = 5'd9;
        id_rs1        = 5'd9;
        #1;
        n_checks++;
        if (outs !== O_RUN) begin
            n_fail++; $display("FAIL no_load_no_stall: got %b expected %b", outs, O_RUN);
        end
        tick();
        idle();
    endtask

    task automatic test_branch();
        ex_branch_taken = 1'b1;
        #1;
        n_checks++;
        if (outs !== O_FLUSH || hz_state !== 2'b00) begin
            n_fail++; $display("FAIL br_cycle0: got %b hz=%b expected %b hz=00", outs, hz_state, O_FLUSH);
        end
        tick();
        ex_branch_taken = 1'b0;
        #1;
        n_checks++;
        if (outs !== O_FLUSH || hz_state !== 2'b01) begin
            n_fail++; $display("FAIL br_cycle1: got %b hz=%b expected %b hz=01", outs, hz_state, O_FLUSH);
        end
        tick();
        n_checks++;
        if (outs !== O_RUN || hz_state !== 2'b00) begin
            n_fail++; $display("FAIL br_done: got %b hz=%b expected %b hz=00", outs, hz_state, O_RUN);
        end
        // Branch and load-use together: branch wins, and the flush cycle still masks the hazard.
        ex_branch_taken = 1'b1;
        load_use(5'd4, 5'd4, 5'd0, 1'b0);
        #1;
        n_checks++;
        if (outs !== O_FLUSH) begin
            n_fail++; $display("FAIL br_beats_lu: got %b expected %b", outs, O_FLUSH);
        end
        tick();
        ex_branch_taken = 1'b0;
        #1;
        n_checks++;
        if (outs !== O_FLUSH || hz_state !== 2'b01) begin
            n_fail++; $display("FAIL flush_beats_lu: got %b hz=%b expected %b hz=01", outs, hz_state, O_FLUSH);
        end
        tick();
        n_checks++;
        if (outs !== O_STALL || hz_state !== 2'b00) begin
            n_fail++; $display("FAIL lu_after_flush: got %b hz=%b expected %b hz=00", outs, hz_state, O_STALL);
        end
        idle();
        // Second branch inside the window restarts it.
        ex_branch_taken = 1'b1;
        tick();
        tick();
        ex_branch_taken = 1'b0;
        #1;
        n_checks++;
        if (outs !== O_FLUSH || hz_state !== 2'b01) begin
            n_fail++; $display("FAIL br_restart: got %b hz=%b expected %b hz=01", outs, hz_state, O_FLUSH);
        end
        tick();
        n_checks++;
        if (hz_state !== 2'b00) begin
            n_fail++; $display("FAIL br_restart_end: hz=%b expected 00", hz_state);
        end
        idle();
    endtask

    task automatic test_freeze_in_flush();
        ex_branch_taken = 1'b1;
        tick();
        ex_branch_taken = 1'b0;
        dmem_busy       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (outs !== O_FREEZE || hz_state !== 2'b01) begin
                n_fail++; $display("FAIL freeze_hold[%0d]: got %b hz=%b expected %b hz=01", i, outs, hz_state, O_FREEZE);
            end
            tick();
        end
        dmem_busy = 1'b0;
        #1;
        n_checks++;
        if (outs !== O_FLUSH || hz_state !== 2'b01) begin
            n_fail++; $display("FAIL freeze_resume: got %b hz=%b expected %b hz=01", outs, hz_state, O_FLUSH);
        end
        tick();
        n_checks++;
        if (outs !== O_RUN || hz_state !== 2'b00) begin
            n_fail++; $display("FAIL freeze_flush_end: got %b hz=%b expected %b hz=00", outs, hz_state, O_RUN);
        end
        // A branch during a freeze is dropped.
        dmem_busy       = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        n_checks++;
        if (outs !== O_FREEZE) begin
            n_fail++; $display("FAIL freeze_beats_br: got %b expected %b", outs, O_FREEZE);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (outs !== O_RUN || hz_state !== 2'b00) begin
            n_fail++; $display("FAIL br_ignored: got %b hz=%b expected %b hz=00", outs, hz_state, O_RUN);
        end
        tick();
    endtask

    task automatic test_timeout();
        dmem_busy = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i == 63) begin
                n_checks++;
                if (freeze_timeout !== 1'b0) begin
                    n_fail++; $display("FAIL tmo_early: got %b expected 0 after edge 63", freeze_timeout);
                end
            end
        end
        n_checks++;
        if (freeze_timeout !== 1'b1 || outs !== O_FREEZE) begin
            n_fail++; $display("FAIL tmo_set: tmo=%b outs=%b expected 1/%b", freeze_timeout, outs, O_FREEZE);
        end
        dmem_busy = 1'b0;
        tick();
        tick();
        n_checks++;
        if (freeze_timeout !== 1'b1 || outs !== O_RUN) begin
            n_fail++; $display("FAIL tmo_sticky: tmo=%b outs=%b expected 1/%b", freeze_timeout, outs, O_RUN);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (freeze_timeout !== 1'b0) begin
            n_fail++; $display("FAIL tmo_clear: got %b expected 0", freeze_timeout);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_flush();
        for (int i = 0; i < 3; i++) begin
            load_use(5'd6, 5'd6, 5'd0, 1'b0);
            tick();
            idle();
            tick();
        end
`ifdef HAZARD_PERF_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'd3) begin
            n_fail++; $display("FAIL perf_stalls: got %0d expected 3", stall_cnt);
        end
`endif
        ex_branch_taken = 1'b1;
        tick();
        ex_branch_taken = 1'b0;
        #1;
        n_checks++;
        if (hz_state !== 2'b01) begin
            n_fail++; $display("FAIL rst_pre_flush: hz=%b expected 01", hz_state);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (hz_state !== 2'b00 || outs !== O_RESET) begin
            n_fail++; $display("FAIL rst_mid_flush: hz=%b outs=%b expected 00/%b", hz_state, outs, O_RESET);
        end
        n_checks++;
        if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin
            n_fail++; $display("FAIL rst_cnt: stall=%0d flush=%0d expected 0/0", stall_cnt, flush_cnt);
        end
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (outs !== O_RUN || hz_state !== 2'b00) begin
            n_fail++; $display("FAIL rst_recover: got %b hz=%b expected %b hz=00", outs, hz_state, O_RUN);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0();
        test_branch();
        test_freeze_in_flush();
        test_timeout();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
